// File: rtl/hazard_pkg.sv
// hazard_pkg: FSM states, register-zero index and stage-control bundle for the hazard unit
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      MULDIV = 2'd1,
      DRAIN  = 2'd2
   } hz_state_e;

   localparam int REG_ZERO = 0;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_keep;
      logic id_ex_en;
      logic id_ex_keep;
      logic ex_mem_en;
      logic ex_mem_keep;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_RUN = '1;

   localparam stage_ctrl_t CTRL_RESET = '{
      pc_en:       1'b0,
      if_id_en:    1'b1,
      if_id_keep:  1'b0,
      id_ex_en:    1'b1,
      id_ex_keep:  1'b0,
      ex_mem_en:   1'b1,
      ex_mem_keep: 1'b0
   };

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// pipeline_hazard_unit_if: decode/execute hazard inputs and stage-register controls
interface pipeline_hazard_unit_if #(
   parameter int RAW = 5
);
   logic [RAW-1:0] id_rs;
   logic [RAW-1:0] id_rt;
   logic           id_uses_rs;
   logic           id_uses_rt;
   logic           id_jump;
   logic           ex_mem_read;
   logic [RAW-1:0] ex_rt;
   logic           ex_branch_taken;
   logic           ex_muldiv_start;
   logic           pc_enable;
   logic           if_id_enable;
   logic           if_id_keep;
   logic           id_ex_enable;
   logic           id_ex_keep;
   logic           ex_mem_enable;
   logic           ex_mem_keep;
   logic           stall_busy;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
             ex_mem_read, ex_rt, ex_branch_taken, ex_muldiv_start,
      input  pc_enable, if_id_enable, if_id_keep, id_ex_enable, id_ex_keep,
             ex_mem_enable, ex_mem_keep, stall_busy
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
             ex_mem_read, ex_rt, ex_branch_taken, ex_muldiv_start,
      output pc_enable, if_id_enable, if_id_keep, id_ex_enable, id_ex_keep,
             ex_mem_enable, ex_mem_keep, stall_busy
   );
endinterface

// File: rtl/hazard_stall_counter.sv
// hazard_stall_counter: loadable down-counter with zero flag, timing the mult/div stall
module hazard_stall_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: stall/flush control for load-use, branch, jump and mult/div hazards
// HAZARD_PERF_COUNTERS_EN adds saturating stall_cycles / flush_events outputs.
module pipeline_hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MULDIV_LATENCY = 32,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_hazard_unit_if.slave hz
`ifdef HAZARD_PERF_COUNTERS_EN
   ,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_events
`endif
);
   hz_state_e   state_q, state_d;
   stage_ctrl_t ctrl;
   logic        load_use, muldiv_stall, cnt_load, cnt_dec, cnt_zero;

   hazard_stall_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk        (clk),
      .rst        (reset),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .load_val_i (CNT_WIDTH'(MULDIV_LATENCY - 2)),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      load_use = hz.ex_mem_read && hz.ex_rt != REG_ADDR_WIDTH'(REG_ZERO) &&
                 ((hz.id_uses_rs && hz.id_rs == hz.ex_rt) || (hz.id_uses_rt && hz.id_rt == hz.ex_rt));
      muldiv_stall = state_q == MULDIV || (state_q == RUN && hz.ex_muldiv_start);
      ctrl     = CTRL_RUN;
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      if (reset) begin
         ctrl    = CTRL_RESET;
         state_d = RUN;
      end else if (muldiv_stall) begin
         ctrl.pc_en       = 1'b0;
         ctrl.if_id_en    = 1'b0;
         ctrl.id_ex_en    = 1'b0;
         ctrl.ex_mem_keep = 1'b0;
         cnt_load         = state_q == RUN;
         cnt_dec          = state_q == MULDIV;
         state_d          = (state_q == RUN || !cnt_zero) ? MULDIV : DRAIN;
      end else begin
         state_d = RUN;
         if (hz.ex_branch_taken) begin
            ctrl.if_id_keep = 1'b0;
            ctrl.id_ex_keep = 1'b0;
         end else if (load_use) begin
            ctrl.pc_en      = 1'b0;
            ctrl.if_id_en   = 1'b0;
            ctrl.id_ex_keep = 1'b0;
         end else if (hz.id_jump) begin
            ctrl.if_id_keep = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   assign hz.pc_enable     = ctrl.pc_en;
   assign hz.if_id_enable  = ctrl.if_id_en;
   assign hz.if_id_keep    = ctrl.if_id_keep;
   assign hz.id_ex_enable  = ctrl.id_ex_en;
   assign hz.id_ex_keep    = ctrl.id_ex_keep;
   assign hz.ex_mem_enable = ctrl.ex_mem_en;
   assign hz.ex_mem_keep   = ctrl.ex_mem_keep;
   assign hz.stall_busy    = state_q != RUN;

`ifdef HAZARD_PERF_COUNTERS_EN
   logic [CNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d;

   always_comb begin
      stall_d = (!ctrl.pc_en && stall_q != '1) ? stall_q + 1'b1 : stall_q;
      flush_d = (!ctrl.if_id_keep && flush_q != '1) ? flush_q + 1'b1 : flush_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed hazard scenarios plus random stimulus against a cycle model
module tb_pipeline_hazard_unit;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail = 0;
   int   m_rem = 0;
   bit   m_drain = 1'b0;
   int   m_stall = 0;
   int   m_flush = 0;

   always #5 clk = ~clk;

   pipeline_hazard_unit_if #(.RAW(5)) hz ();

`ifdef HAZARD_PERF_COUNTERS_EN
   logic [15:0] stall_cycles, flush_events;
   logic [1:0]  stall2, flush2;
   pipeline_hazard_unit_if #(.RAW(5)) hz2 ();
   assign hz2.id_rs           = hz.id_rs;
   assign hz2.id_rt           = hz.id_rt;
   assign hz2.id_uses_rs      = hz.id_uses_rs;
   assign hz2.id_uses_rt      = hz.id_uses_rt;
   assign hz2.id_jump         = hz.id_jump;
   assign hz2.ex_mem_read     = hz.ex_mem_read;
   assign hz2.ex_rt           = hz.ex_rt;
   assign hz2.ex_branch_taken = hz.ex_branch_taken;
   assign hz2.ex_muldiv_start = hz.ex_muldiv_start;
   pipeline_hazard_unit #(.REG_ADDR_WIDTH(5), .MULDIV_LATENCY(LAT), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(rst), .hz(hz), .stall_cycles(stall_cycles), .flush_events(flush_events));
   pipeline_hazard_unit #(.REG_ADDR_WIDTH(5), .MULDIV_LATENCY(LAT), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .reset(rst), .hz(hz2), .stall_cycles(stall2), .flush_events(flush2));
`else
   pipeline_hazard_unit #(.REG_ADDR_WIDTH(5), .MULDIV_LATENCY(LAT), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(rst), .hz(hz));
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return v > mx ? mx : v;
   endfunction

   function automatic logic [7:0] model_exp();
      logic busy, lu;
      busy = m_rem > 0 || m_drain;
      lu = hz.ex_mem_read && hz.ex_rt != 0 &&
           ((hz.id_uses_rs && hz.id_rs == hz.ex_rt) || (hz.id_uses_rt && hz.id_rt == hz.ex_rt));
      if (rst) return {7'b0101010, busy};
      if (m_rem > 0 || (!m_drain && hz.ex_muldiv_start)) return {7'b0010110, busy};
      if (hz.ex_branch_taken) return {7'b1101011, busy};
      if (lu) return {7'b0011011, busy};
      if (hz.id_jump) return {7'b1101111, busy};
      return {7'b1111111, busy};
   endfunction

   task automatic tick(input string tag, output logic [7:0] v);
      logic [7:0] e;
      @(negedge clk);
      e = model_exp();
      v = {hz.pc_enable, hz.if_id_enable, hz.if_id_keep, hz.id_ex_enable, hz.id_ex_keep,
           hz.ex_mem_enable, hz.ex_mem_keep, hz.stall_busy};
      check(tag, 32'(v), 32'(e));
`ifdef HAZARD_PERF_COUNTERS_EN
      check("stall_cnt", 32'(stall_cycles), sat(m_stall, 65535));
      check("flush_cnt", 32'(flush_events), sat(m_flush, 65535));
      check("stall_cnt_w2", 32'(stall2), sat(m_stall, 3));
      check("flush_cnt_w2", 32'(flush2), sat(m_flush, 3));
`endif
      if (rst) begin
         m_rem = 0;
         m_drain = 1'b0;
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (!e[7]) m_stall++;
         if (!e[5]) m_flush++;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_drain = 1'b1;
         end else if (!m_drain && hz.ex_muldiv_start) m_rem = LAT - 1;
         else m_drain = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rs = 0; hz.id_uses_rt = 0; hz.id_jump = 0;
      hz.ex_mem_read = 0; hz.ex_rt = '0; hz.ex_branch_taken = 0; hz.ex_muldiv_start = 0;
   endtask

   initial begin
      logic [7:0] v;
      int zeros;
      clear_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      tick("reset_cycle", v);
      check("reset_vec", 32'(v), 32'(8'b0101_0100));
      rst = 1'b0;
      tick("idle", v);
      check("idle_vec", 32'(v), 32'(8'b1111_1110));
      hz.ex_mem_read = 1; hz.ex_rt = 5'd5; hz.id_rs = 5'd5; hz.id_uses_rs = 1;
      tick("load_use", v);
      check("lu_vec", 32'(v), 32'(8'b0011_0110));
      hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
      tick("load_use_r0", v);
      check("lu_r0_vec", 32'(v), 32'(8'b1111_1110));
      clear_inputs();
      hz.ex_muldiv_start = 1;
      zeros = 0;
      for (int i = 0; i < LAT + 1; i++) begin
         tick("muldiv", v);
         if (!v[7]) zeros++;
      end
      check("muldiv_len", zeros, LAT);
      check("drain_vec", 32'(v), 32'(8'b1111_1111));
      hz.ex_muldiv_start = 0;
      tick("post_drain", v);
      check("post_drain_vec", 32'(v), 32'(8'b1111_1110));
`ifdef HAZARD_PERF_COUNTERS_EN
      check("perf_stall5", 32'(stall_cycles), 5);
      check("perf_sat3", 32'(stall2), 3);
`endif
      hz.ex_mem_read = 1; hz.ex_rt = 5'd5; hz.id_rs = 5'd5; hz.id_uses_rs = 1; hz.ex_branch_taken = 1;
      tick("branch_lu", v);
      check("branch_lu_vec", 32'(v), 32'(8'b1101_0110));
      clear_inputs();
      hz.ex_muldiv_start = 1;
      tick("abort_start", v);
      hz.ex_muldiv_start = 0;
      tick("abort_md1", v);
      rst = 1'b1;
      tick("abort_reset", v);
      check("abort_reset_vec", 32'(v), 32'(8'b0101_0101));
      rst = 1'b0;
      tick("abort_after", v);
      check("abort_after_vec", 32'(v), 32'(8'b1111_1110));
      hz.ex_muldiv_start = 1;
      tick("restart", v);
      hz.ex_muldiv_start = 0;
      for (int i = 0; i < LAT; i++) tick("restart_run", v);
      check("restart_drain", 32'(v[0]), 1);
      for (int i = 0; i < 1500; i++) begin
         hz.id_rs = 5'($urandom_range(0, 3));
         hz.id_rt = 5'($urandom_range(0, 3));
         hz.ex_rt = 5'($urandom_range(0, 3));
         hz.id_uses_rs = ($urandom_range(0, 1) == 1);
         hz.id_uses_rt = ($urandom_range(0, 1) == 1);
         hz.id_jump = ($urandom_range(0, 3) == 0);
         hz.ex_mem_read = ($urandom_range(0, 1) == 1);
         hz.ex_branch_taken = ($urandom_range(0, 5) == 0);
         hz.ex_muldiv_start = ($urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 49) == 0);
         tick("random", v);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
